// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI multi-byte transaction sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        WAIT_DONE,
        STORE,
        GAP,
        FINISH
    } state_t;

    localparam int unsigned GAP_CYCLES_DEF     = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
    // Widest last-index the config struct can carry; ADDR_W must not exceed it.
    localparam int unsigned CFG_ADDR_MAX       = 16;

    typedef struct packed {
        logic [CFG_ADDR_MAX-1:0] n_tx_end;
        logic                    all_1s;
        logic                    all_0s;
    } seq_cfg_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_transaction_sequencer_if.sv
// Command, TX/RX RAM and byte-engine signals of the transaction sequencer.
interface spi_transaction_sequencer_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              start_i;
    logic              abort_i;
    logic [ADDR_W-1:0] n_tx_end_i;
    logic              all_1s_i;
    logic              all_0s_i;
    logic [ADDR_W-1:0] tx_addr_o;
    logic [7:0]        tx_rdata_i;
    logic              spi_send_o;
    logic [7:0]        spi_tx_data_o;
    logic              spi_all_1s_o;
    logic              spi_all_0s_o;
    logic              spi_done_i;
    logic [7:0]        spi_rx_data_i;
    logic              rx_we_o;
    logic [ADDR_W-1:0] rx_addr_o;
    logic [7:0]        rx_wdata_o;
    logic [ADDR_W:0]   n_rx_end_o;
    logic              busy_o;
    logic              done_o;
    logic              timeout_o;

    modport master (
        input  start_i, abort_i, n_tx_end_i, all_1s_i, all_0s_i,
        input  tx_rdata_i, spi_done_i, spi_rx_data_i,
        output tx_addr_o, spi_send_o, spi_tx_data_o, spi_all_1s_o, spi_all_0s_o,
        output rx_we_o, rx_addr_o, rx_wdata_o, n_rx_end_o, busy_o, done_o, timeout_o
    );

    modport slave (
        output start_i, abort_i, n_tx_end_i, all_1s_i, all_0s_i,
        output tx_rdata_i, spi_done_i, spi_rx_data_i,
        input  tx_addr_o, spi_send_o, spi_tx_data_o, spi_all_1s_o, spi_all_0s_o,
        input  rx_we_o, rx_addr_o, rx_wdata_o, n_rx_end_o, busy_o, done_o, timeout_o
    );
endinterface

// File: rtl/spi_transaction_sequencer_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module spi_seq_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/spi_transaction_sequencer.sv
// Walks n_tx_end+1 bytes from TX RAM through the SPI byte engine and stores
// each received byte into RX RAM at the same index.
module spi_transaction_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    spi_transaction_sequencer_if.master bus
);
    localparam int unsigned TW = $clog2(max_u(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    state_t            state, state_n;
    seq_cfg_t          cfg;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        tx_data;
    logic [7:0]        rx_byte;
    logic [ADDR_W:0]   n_rx_end;
    logic              timeout;
    logic              abort_pend;
    logic              done_q;
    logic              done_rise;
    logic              last;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_exp;
    logic [TW-1:0]     tmr_val;

    // The engine parks done high between bytes, so only its rising edge counts.
    assign done_rise = bus.spi_done_i & ~done_q;
    assign last      = (cfg.n_tx_end == CFG_ADDR_MAX'(idx));

    spi_seq_timer #(.W(TW)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (tmr_load),
        .load_val(tmr_val),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        case (state)
            IDLE:  if (bus.start_i) state_n = FETCH;
            FETCH: state_n = bus.abort_i ? FINISH : LOAD;
            LOAD:  state_n = bus.abort_i ? FINISH : SEND;
            SEND: begin
                state_n  = WAIT_DONE;
                tmr_load = 1'b1;
                tmr_val  = TW'(TIMEOUT_CYCLES - 1);
            end
            WAIT_DONE: begin
                tmr_en = 1'b1;
                if (done_rise)    state_n = STORE;
                else if (tmr_exp) state_n = FINISH;
            end
            STORE: begin
                // A byte in flight always lands; a pending abort takes effect here.
                if (last || abort_pend || bus.abort_i) begin
                    state_n = FINISH;
                end else begin
                    state_n  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                tmr_en = 1'b1;
                if (bus.abort_i)  state_n = FINISH;
                else if (tmr_exp) state_n = FETCH;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg        <= '0;
            idx        <= '0;
            tx_data    <= '0;
            rx_byte    <= '0;
            n_rx_end   <= '0;
            timeout    <= 1'b0;
            abort_pend <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= bus.spi_done_i;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        cfg.n_tx_end <= CFG_ADDR_MAX'(bus.n_tx_end_i);
                        cfg.all_1s   <= bus.all_1s_i;
                        cfg.all_0s   <= bus.all_0s_i & ~bus.all_1s_i;
                        idx          <= '0;
                        n_rx_end     <= '0;
                        timeout      <= 1'b0;
                        abort_pend   <= 1'b0;
                    end
                end
                LOAD: tx_data <= bus.tx_rdata_i;
                SEND: if (bus.abort_i) abort_pend <= 1'b1;
                WAIT_DONE: begin
                    if (bus.abort_i) abort_pend <= 1'b1;
                    if (done_rise)    rx_byte <= bus.spi_rx_data_i;
                    else if (tmr_exp) timeout <= 1'b1;
                end
                STORE: begin
                    n_rx_end <= n_rx_end + 1'b1;
                    if (!last) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_addr_o     = idx;
    assign bus.spi_send_o    = (state == SEND);
    assign bus.spi_tx_data_o = tx_data;
    assign bus.spi_all_1s_o  = cfg.all_1s;
    assign bus.spi_all_0s_o  = cfg.all_0s;
    assign bus.rx_we_o       = (state == STORE);
    assign bus.rx_addr_o     = idx;
    assign bus.rx_wdata_o    = rx_byte;
    assign bus.n_rx_end_o    = n_rx_end;
    assign bus.busy_o        = (state != IDLE);
    assign bus.done_o        = (state == FINISH);
    assign bus.timeout_o     = timeout;
endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Randomized bench for spi_transaction_sequencer with a transaction-level
// model, an engine/RAM model and a per-cycle compare process.
module tb_spi_transaction_sequencer;
    localparam int AW    = 9;
    localparam int GAP   = 16;
    localparam int TMO   = 1024;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_transaction_sequencer_if #(.ADDR_W(AW)) ifc ();

    spi_transaction_sequencer #(
        .ADDR_W(AW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (ifc)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0] tx_mem [512];
    logic [7:0] resp   [512];
    logic [7:0] rx_ram [512];
    int         dly    [512];

    // Expectations for the running transaction, set by the driver.
    int exp_sends  = 0;
    int exp_writes = 0;
    bit exp_tmo    = 1'b0;

    // Model state owned by the compare process.
    int cyc = 0, start_cyc = -100, send_cnt = 0, wr_cnt = 0;
    int last_send_cyc = 0, rise_cyc = -100, last_we_cyc = 0, last_wr_addr = -1;
    int done_cnt = 0, done_cyc = -100;
    bit prev_done = 1'b0, l1 = 1'b0, l0 = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [50:0] outs();
        return {ifc.tx_addr_o, ifc.spi_send_o, ifc.spi_tx_data_o, ifc.spi_all_1s_o,
                ifc.spi_all_0s_o, ifc.rx_we_o, ifc.rx_addr_o, ifc.rx_wdata_o,
                ifc.n_rx_end_o, ifc.busy_o, ifc.done_o, ifc.timeout_o};
    endfunction

    // TX RAM: data for the address seen in one cycle appears the next cycle.
    initial begin
        logic [AW-1:0] a;
        ifc.tx_rdata_i = '0;
        forever begin
            @(negedge clk);
            a = ifc.tx_addr_o;
            @(posedge clk);
            #1 ifc.tx_rdata_i = tx_mem[a];
        end
    end

    // Byte engine: done drops on send, rises dly[] cycles later (0 = never).
    initial begin
        int cnt, eidx;
        cnt = 0;
        eidx = 0;
        ifc.spi_done_i    = 1'b0;
        ifc.spi_rx_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = 0;
                ifc.spi_done_i = 1'b0;
            end else begin
                if (!ifc.busy_o) eidx = 0;
                if (ifc.spi_send_o) begin
                    ifc.spi_done_i = 1'b0;
                    cnt = (eidx < 512) ? dly[eidx] : 1;
                    eidx++;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        ifc.spi_done_i    = 1'b1;
                        ifc.spi_rx_data_i = resp[eidx-1];
                    end
                end
            end
        end
    end

    // Compare process: checks outputs against the transaction model each cycle.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (ifc.start_i && !ifc.busy_o) begin
                start_cyc = cyc;
                send_cnt  = 0;
                wr_cnt    = 0;
                l1 = ifc.all_1s_i;
                l0 = ifc.all_0s_i & ~ifc.all_1s_i;
            end
            if (cyc == start_cyc + 1) begin
                chk("start_busy", ifc.busy_o, 1);
                chk("start_clears_timeout", ifc.timeout_o, 0);
                chk("start_clears_nrx", ifc.n_rx_end_o, 0);
            end
            if (ifc.spi_done_i && !prev_done) rise_cyc = cyc;
            prev_done = ifc.spi_done_i;
            if (ifc.spi_send_o) begin
                chk("send_allowed", send_cnt < exp_sends, 1);
                chk("send_data", ifc.spi_tx_data_o, tx_mem[send_cnt]);
                if (send_cnt == 0) chk("start_to_send", cyc - start_cyc, 3);
                else chk("send_spacing", cyc - last_send_cyc, dly[send_cnt-1] + GAP + 4);
                chk("fill_1s", ifc.spi_all_1s_o, l1);
                chk("fill_0s", ifc.spi_all_0s_o, l0);
                last_send_cyc = cyc;
                send_cnt++;
            end
            if (ifc.rx_we_o) begin
                chk("wr_addr", ifc.rx_addr_o, wr_cnt);
                chk("wr_data", ifc.rx_wdata_o, resp[wr_cnt]);
                chk("done_to_write", cyc - rise_cyc, 1);
                rx_ram[ifc.rx_addr_o] = ifc.rx_wdata_o;
                last_wr_addr = int'(ifc.rx_addr_o);
                last_we_cyc  = cyc;
                wr_cnt++;
            end
            if (ifc.done_o) begin
                chk("done_sends", send_cnt, exp_sends);
                chk("done_writes", wr_cnt, exp_writes);
                chk("done_nrx", ifc.n_rx_end_o, exp_writes);
                chk("done_timeout", ifc.timeout_o, exp_tmo);
                if (exp_tmo) chk("timeout_latency", cyc - last_send_cyc, TMO + 1);
                else         chk("store_to_done", cyc - last_we_cyc, 1);
                done_cyc = cyc;
                done_cnt++;
            end
            if (cyc == done_cyc + 1) chk("busy_falls", ifc.busy_o, 0);
        end
    end

    task automatic fill(input int n);
        for (int i = 0; i <= n; i++) begin
            tx_mem[i] = 8'($urandom);
            resp[i]   = 8'($urandom);
            dly[i]    = $urandom_range(1, 12);
        end
    endtask

    task automatic run_txn(input int n, input bit f1, input bit f0, input int abort_at,
                           input bit tmo, input bit busy_start);
        int d0, s, b;
        exp_tmo    = tmo;
        exp_sends  = tmo ? 1 : ((abort_at >= 0) ? abort_at + 1 : n + 1);
        exp_writes = tmo ? 0 : exp_sends;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        ifc.n_tx_end_i = n[AW-1:0];
        ifc.all_1s_i   = f1;
        ifc.all_0s_i   = f0;
        ifc.start_i    = 1'b1;
        @(posedge clk);
        #1;
        ifc.start_i    = 1'b0;
        ifc.n_tx_end_i = AW'($urandom);
        ifc.all_1s_i   = 1'($urandom);
        ifc.all_0s_i   = 1'($urandom);
        if (busy_start) begin
            @(posedge clk);
            #1 ifc.start_i = 1'b1;
            @(posedge clk);
            #1 ifc.start_i = 1'b0;
        end
        if (abort_at >= 0) begin
            s = 0;
            b = 0;
            while (s < abort_at + 1 && b < LIMIT) begin
                @(negedge clk);
                if (ifc.spi_send_o) s++;
                b++;
            end
            @(posedge clk);
            #1 ifc.abort_i = 1'b1;
            @(posedge clk);
            #1 ifc.abort_i = 1'b0;
        end
        b = 0;
        while (done_cnt == d0 && b < LIMIT) begin
            @(negedge clk);
            b++;
        end
        chk("txn_completes", done_cnt != d0, 1);
        repeat (3) @(negedge clk);
        chk("one_done", done_cnt - d0, 1);
    endtask

    initial begin
        int b, n, ab;
        ifc.start_i    = 1'b0;
        ifc.abort_i    = 1'b0;
        ifc.n_tx_end_i = '0;
        ifc.all_1s_i   = 1'b0;
        ifc.all_0s_i   = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk("reset_outs", outs(), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) chk("idle_outs", outs(), 0);

        // Single byte
        tx_mem[0] = 8'hA5;
        resp[0]   = 8'h3C;
        dly[0]    = 40;
        run_txn(0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        chk("single_rx0", rx_ram[0], 8'h3C);
        chk("single_nrx", ifc.n_rx_end_o, 1);
        chk("single_sends", send_cnt, 1);

        // Multi-byte echo, both fill flags set
        tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33; tx_mem[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            resp[i] = tx_mem[i];
            dly[i]  = i + 3;
        end
        run_txn(3, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        chk("multi_rx0", rx_ram[0], 8'h11);
        chk("multi_rx1", rx_ram[1], 8'h22);
        chk("multi_rx2", rx_ram[2], 8'h33);
        chk("multi_rx3", rx_ram[3], 8'h44);
        chk("multi_nrx", ifc.n_rx_end_o, 4);
        chk("multi_sends", send_cnt, 4);
        chk("multi_fill_0s", ifc.spi_all_0s_o, 0);

        // Full range
        for (int i = 0; i < 512; i++) begin
            tx_mem[i] = 8'($urandom);
            resp[i]   = 8'($urandom);
            dly[i]    = $urandom_range(1, 3);
        end
        run_txn(511, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        chk("full_nrx", ifc.n_rx_end_o, 512);
        chk("full_writes", wr_cnt, 512);
        chk("full_last_addr", last_wr_addr, 511);

        // Timeout, then a new start clears it
        fill(2);
        dly[0] = 0;
        run_txn(2, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        chk("tmo_flag", ifc.timeout_o, 1);
        chk("tmo_nrx", ifc.n_rx_end_o, 0);
        fill(1);
        run_txn(1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        chk("tmo_cleared", ifc.timeout_o, 0);

        // Abort in WAIT_DONE of byte 1 of 4
        fill(3);
        run_txn(3, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        chk("abort_nrx", ifc.n_rx_end_o, 2);
        chk("abort_sends", send_cnt, 2);

        // Start while busy is ignored
        fill(2);
        run_txn(2, 1'b1, 1'b0, -1, 1'b0, 1'b1);
        chk("busy_start_nrx", ifc.n_rx_end_o, 3);

        // Reset during WAIT_DONE
        fill(3);
        dly[0] = 30;
        exp_sends = 4; exp_writes = 4; exp_tmo = 1'b0;
        @(posedge clk);
        #1;
        ifc.n_tx_end_i = 9'd3;
        ifc.start_i    = 1'b1;
        @(posedge clk);
        #1 ifc.start_i = 1'b0;
        b = 0;
        while (!ifc.spi_send_o && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("rst_mid_send_seen", ifc.spi_send_o, 1);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset_outs", outs(), 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        fill(2);
        run_txn(2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        chk("post_reset_nrx", ifc.n_rx_end_o, 3);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 7);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            fill(n);
            run_txn(n, 1'($urandom), 1'($urandom), ab, 1'b0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
